// File: rtl/zsdram_frame_reader.sv
// Frame-buffer read path: fetches pixels one word at a time from the SDRAM read port into a prefetch FIFO
// and serves one RGB565 pixel per LCD request. Optional underrun counter: ZFRAME_READER_UNDERRUN_CNT_EN.
module zsdram_frame_reader #(
    parameter int unsigned FRAME_PIXELS   = 384000,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter logic [15:0] UNDERRUN_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        iSDRAM_Draw_Done,
    input  logic        iFrame_Start,
    output logic [23:0] oSDRAM_Rd_Addr,
    output logic        oSDRAM_Rd_Req,
    input  logic        iSDRAM_Rd_Done,
    input  logic [15:0] iSDRAM_Rd_Data,
    input  logic        iLCD_Pix_Req,
    output logic [15:0] oLCD_Pix_Data,
    output logic        oLCD_Pix_Valid,
    output logic        oUnderrun
`ifdef ZFRAME_READER_UNDERRUN_CNT_EN
    ,
    output logic [15:0] oUnderrun_Cnt
`endif
);

    localparam int unsigned         PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]      DEPTH_CNT = {1'b1, {PTR_W{1'b0}}};
    localparam logic [23:0]         LAST_ADDR = 24'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_NEXT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [23:0]       addr_q, addr_d;
    logic              req_q, req_d;
    logic              frame_ready_q, frame_ready_d;
    logic              start_pend_q, start_pend_d;

    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              fifo_full, fifo_empty;

    logic [15:0]       pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;
    logic              underrun_q, underrun_d;

    logic              start_req, rd_ack, restart, push, pop;

    assign fifo_full  = (count_q == DEPTH_CNT);
    assign fifo_empty = (count_q == '0);

    // Fetch control. A pending frame start may only restart the scan while no read is
    // outstanding, so a read in flight always completes and its word is then dropped.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        addr_d        = addr_q;
        req_d         = req_q;
        frame_ready_d = frame_ready_q | iSDRAM_Draw_Done;
        start_req     = start_pend_q | (iFrame_Start & frame_ready_q);
        start_pend_d  = start_req;
        rd_ack        = req_q & iSDRAM_Rd_Done;
        restart       = 1'b0;
        push          = 1'b0;

        if (rd_ack) begin
            req_d   = 1'b0;
            push    = ~start_req;
            state_d = S_NEXT;
        end else if (en && !req_q && start_req) begin
            restart      = 1'b1;
            addr_d       = '0;
            start_pend_d = 1'b0;
            state_d      = S_FILL;
        end else if (en) begin
            case (state_q)
                S_IDLE: ;
                S_FILL: if (!req_q && !fifo_full) req_d = 1'b1;
                S_NEXT: begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_q + 24'd1;
                        state_d = S_FILL;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FIFO bookkeeping and LCD side; a pop on empty yields the underrun colour instead.
    always_comb begin
        pop         = iLCD_Pix_Req & ~fifo_empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pix_valid_d = iLCD_Pix_Req;
        underrun_d  = iLCD_Pix_Req & fifo_empty;
        pix_data_d  = pix_data_q;

        if (iLCD_Pix_Req) pix_data_d = fifo_empty ? UNDERRUN_COLOR : fifo_mem[rd_ptr_q];

        if (restart) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            req_q         <= 1'b0;
            frame_ready_q <= 1'b0;
            start_pend_q  <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            req_q         <= req_d;
            frame_ready_q <= frame_ready_d;
            start_pend_q  <= start_pend_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            underrun_q    <= underrun_d;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= iSDRAM_Rd_Data;
    end

    assign oSDRAM_Rd_Addr = addr_q;
    assign oSDRAM_Rd_Req  = req_q;
    assign oLCD_Pix_Data  = pix_data_q;
    assign oLCD_Pix_Valid = pix_valid_q;
    assign oUnderrun      = underrun_q;

`ifdef ZFRAME_READER_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (restart)                              ucnt_d = '0;
        else if (underrun_d && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ucnt_q <= '0;
        else        ucnt_q <= ucnt_d;
    end

    assign oUnderrun_Cnt = ucnt_q;
`endif

endmodule
